// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: MSB-first bit stream with SOF/EOF markers and a post-word gap.
// Optional golden divisible-by-3 reference output enabled by defining SERIAL_TX_DIV3_REF_EN.
module serial_word_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_sof,
  output logic                  dout_eof,
  output logic                  busy
`ifdef SERIAL_TX_DIV3_REF_EN
  ,
  output logic                  exp_div3
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  shifting;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (din_valid && din_ready) begin
          shift_d   = din;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          gap_cnt_d = '0;
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // din_ready is the only output allowed to see reset combinationally.
  assign shifting   = (state_q == SHIFT);
  assign din_ready  = (state_q == IDLE) && !reset;
  assign dout       = shifting && shift_q[DATA_WIDTH-1];
  assign dout_valid = shifting;
  assign dout_sof   = shifting && (bit_cnt_q == '0);
  assign dout_eof   = shifting && (bit_cnt_q == BIT_LAST);
  assign busy       = (state_q != IDLE);

`ifdef SERIAL_TX_DIV3_REF_EN
  logic [1:0] res_q, res_d;
  logic [1:0] res_used;
  logic [2:0] res_sum;
  logic [1:0] res_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  // Residue restarts on the SOF bit so each word is judged independently.
  always_comb begin
    res_used = dout_sof ? 2'd0 : res_q;
    res_sum  = {res_used, 1'b0} + {2'b00, dout};
    res_next = (res_sum >= 3'd3) ? 2'(res_sum - 3'd3) : res_sum[1:0];
    res_d    = shifting ? res_next : res_q;
  end

  assign exp_div3 = shifting && (res_next == 2'd0);
`endif

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: three instances (8/1, 8/0, 1/1) checked at the falling edge.
module tb_serial_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_TX_DIV3_REF_EN
  localparam bit DIV3 = 1'b1;
`else
  localparam bit DIV3 = 1'b0;
`endif

  logic       a_reset, a_din_valid, a_ready, a_dout, a_valid, a_sof, a_eof, a_busy, a_exp;
  logic [7:0] a_din;
  logic       b_reset, b_din_valid, b_ready, b_dout, b_valid, b_sof, b_eof, b_busy, b_exp;
  logic [7:0] b_din;
  logic       c_reset, c_din_valid, c_ready, c_dout, c_valid, c_sof, c_eof, c_busy, c_exp;
  logic [0:0] c_din;

  serial_word_tx #(.DATA_WIDTH(8), .GAP_CYCLES(1)) u_a (
    .clk(clk), .reset(a_reset), .din(a_din), .din_valid(a_din_valid), .din_ready(a_ready),
    .dout(a_dout), .dout_valid(a_valid), .dout_sof(a_sof), .dout_eof(a_eof), .busy(a_busy)
`ifdef SERIAL_TX_DIV3_REF_EN
    , .exp_div3(a_exp)
`endif
  );

  serial_word_tx #(.DATA_WIDTH(8), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(b_reset), .din(b_din), .din_valid(b_din_valid), .din_ready(b_ready),
    .dout(b_dout), .dout_valid(b_valid), .dout_sof(b_sof), .dout_eof(b_eof), .busy(b_busy)
`ifdef SERIAL_TX_DIV3_REF_EN
    , .exp_div3(b_exp)
`endif
  );

  serial_word_tx #(.DATA_WIDTH(1), .GAP_CYCLES(1)) u_c (
    .clk(clk), .reset(c_reset), .din(c_din), .din_valid(c_din_valid), .din_ready(c_ready),
    .dout(c_dout), .dout_valid(c_valid), .dout_sof(c_sof), .dout_eof(c_eof), .busy(c_busy)
`ifdef SERIAL_TX_DIV3_REF_EN
    , .exp_div3(c_exp)
`endif
  );

`ifndef SERIAL_TX_DIV3_REF_EN
  assign a_exp = 1'b0;
  assign b_exp = 1'b0;
  assign c_exp = 1'b0;
`endif

  task automatic test_reset();
    logic [6:0] got;
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_din_valid = 1'b0; b_din_valid = 1'b0; c_din_valid = 1'b0;
    a_din = '0; b_din = '0; c_din = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, b_ready, c_ready} !== 3'b000)
      $display("FAIL reset_ready_low got %b want 000", {a_ready, b_ready, c_ready});
    if ({a_ready, b_ready, c_ready} !== 3'b000) errors++;
    @(negedge clk);
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
    #1;
    got = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready, a_exp};
    checks++;
    if (got !== 7'b0000010) begin
      $display("FAIL reset_a got %b want 0000010", got); errors++;
    end
    got = {b_dout, b_valid, b_sof, b_eof, b_busy, b_ready, b_exp};
    checks++;
    if (got !== 7'b0000010) begin
      $display("FAIL reset_b got %b want 0000010", got); errors++;
    end
    got = {c_dout, c_valid, c_sof, c_eof, c_busy, c_ready, c_exp};
    checks++;
    if (got !== 7'b0000010) begin
      $display("FAIL reset_c got %b want 0000010", got); errors++;
    end
  endtask

  task automatic test_a5();
    logic [7:0] word;
    logic [5:0] got, want;
    word = 8'hA5;
    @(negedge clk);
    a_din = word; a_din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_din_valid = 1'b0;
      got  = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready};
      want = {word[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        $display("FAIL a5_bit%0d got %b want %b", i, got, want); errors++;
      end
    end
    @(negedge clk);
    got = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready};
    checks++;
    if (got !== 6'b000010) begin
      $display("FAIL a5_gap got %b want 000010", got); errors++;
    end
    @(negedge clk);
    got = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready};
    checks++;
    if (got !== 6'b000001) begin
      $display("FAIL a5_idle got %b want 000001", got); errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got, want;
    @(negedge clk);
    b_din = 8'hFF; b_din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) b_din = 8'h00;
      got  = {b_dout, b_valid, b_sof, b_eof, b_busy, b_ready};
      want = {1'b1, 1'b1, (i == 0), (i == 7), 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        $display("FAIL b2b_w0_bit%0d got %b want %b", i, got, want); errors++;
      end
    end
    @(negedge clk);
    got = {b_dout, b_valid, b_sof, b_eof, b_busy, b_ready};
    checks++;
    if (got !== 6'b000001) begin
      $display("FAIL b2b_accept2 got %b want 000001", got); errors++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) b_din_valid = 1'b0;
      if (i == 2) b_din = 8'hFF;
      got  = {b_dout, b_valid, b_sof, b_eof, b_busy, b_ready};
      want = {1'b0, 1'b1, (i == 0), (i == 7), 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        $display("FAIL b2b_w1_bit%0d got %b want %b", i, got, want); errors++;
      end
    end
    @(negedge clk);
    got = {b_dout, b_valid, b_sof, b_eof, b_busy, b_ready};
    checks++;
    if (got !== 6'b000001) begin
      $display("FAIL b2b_idle got %b want 000001", got); errors++;
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] word;
    logic [6:0] got7;
    logic [5:0] got, want;
    word = 8'hC3;
    @(negedge clk);
    a_din = word; a_din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) a_din_valid = 1'b0;
      got  = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready};
      want = {word[7-i], 1'b1, (i == 0), 1'b0, 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        $display("FAIL rst_pre_bit%0d got %b want %b", i, got, want); errors++;
      end
    end
    a_reset = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      $display("FAIL rst_ready_during got %b want 0", a_ready); errors++;
    end
    @(negedge clk);
    a_reset = 1'b0;
    #1;
    got7 = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready, a_exp};
    checks++;
    if (got7 !== 7'b0000010) begin
      $display("FAIL rst_after got %b want 0000010", got7); errors++;
    end
    word = 8'h81;
    a_din = word; a_din_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_din_valid = 1'b0;
      got  = {a_dout, a_valid, a_sof, a_eof, a_busy, a_ready};
      want = {word[7-i], 1'b1, (i == 0), (i == 7), 1'b1, 1'b0};
      checks++;
      if (got !== want) begin
        $display("FAIL rst_next_bit%0d got %b want %b", i, got, want); errors++;
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (a_ready !== 1'b1) begin
      $display("FAIL rst_final_ready got %b want 1", a_ready); errors++;
    end
  endtask

  task automatic test_width1();
    logic [6:0] got;
    @(negedge clk);
    c_din = 1'b1; c_din_valid = 1'b1;
    @(negedge clk);
    c_din_valid = 1'b0;
    got = {c_dout, c_valid, c_sof, c_eof, c_busy, c_ready, c_exp};
    checks++;
    if (got !== 7'b1111100) begin
      $display("FAIL w1_one got %b want 1111100", got); errors++;
    end
    @(negedge clk);
    got = {c_dout, c_valid, c_sof, c_eof, c_busy, c_ready, c_exp};
    checks++;
    if (got !== 7'b0000100) begin
      $display("FAIL w1_gap got %b want 0000100", got); errors++;
    end
    @(negedge clk);
    got = {c_dout, c_valid, c_sof, c_eof, c_busy, c_ready, c_exp};
    checks++;
    if (got !== 7'b0000010) begin
      $display("FAIL w1_idle got %b want 0000010", got); errors++;
    end
    c_din = 1'b0; c_din_valid = 1'b1;
    @(negedge clk);
    c_din_valid = 1'b0;
    got = {c_dout, c_valid, c_sof, c_eof, c_busy, c_ready, c_exp};
    checks++;
    if (got !== {6'b011110, DIV3}) begin
      $display("FAIL w1_zero got %b want %b", got, {6'b011110, DIV3}); errors++;
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SERIAL_TX_DIV3_REF_EN
  task automatic test_div3();
    logic [7:0] words [2];
    logic [7:0] wants [2];
    logic [7:0] word, want;
    logic [1:0] got;
    // 0x0B leaves residue 2, so 0x06 also proves the residue restarts on SOF.
    words[0] = 8'h0B; wants[0] = 8'b11110000;
    words[1] = 8'h06; wants[1] = 8'b11111011;
    for (int w = 0; w < 2; w++) begin
      word = words[w];
      want = wants[w];
      @(negedge clk);
      a_din = word; a_din_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0) a_din_valid = 1'b0;
        got = {a_dout, a_exp};
        checks++;
        if (got !== {word[7-i], want[7-i]}) begin
          $display("FAIL div3_w%0d_bit%0d got %b want %b", w, i, got, {word[7-i], want[7-i]});
          errors++;
        end
      end
      @(negedge clk);
      checks++;
      if (a_exp !== 1'b0) begin
        $display("FAIL div3_w%0d_gap got %b want 0", w, a_exp); errors++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_a5();
    test_back_to_back();
    test_reset_mid_word();
    test_width1();
`ifdef SERIAL_TX_DIV3_REF_EN
    test_div3();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
# serial_word_tx

Parallel-to-serial transmitter for the bit-serial number stream consumed by the divisibility-checking blocks. It accepts one DATA_WIDTH-bit word through a valid/ready handshake and emits it MSB-first, one bit per clock, with start-of-frame and end-of-frame markers. Downstream receivers use `dout_sof` to restart their running residue. An optional sidecar computes the expected divisible-by-3 flag per bit as a golden reference for verification.

## Interface
- `DATA_WIDTH`, default 8: word width in bits; minimum 1.
- `GAP_CYCLES`, default 1: idle cycles inserted after each word's last bit; minimum 0.

- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `din`  in  DATA_WIDTH: parallel word; bit DATA_WIDTH-1 is transmitted first.
- `din_valid`  in  1: `din` is valid.
- `din_ready`  out  1: block can accept a word this cycle.
- `dout`  out  1: serial data bit.
- `dout_valid`  out  1: `dout` carries a bit this cycle.
- `dout_sof`  out  1: this cycle carries the first (MSB) bit of a word.
- `dout_eof`  out  1: this cycle carries the last (LSB) bit of a word.
- `busy`  out  1: a word is being shifted out or the post-word gap is running.
- `exp_div3`  out  1: present only when `SERIAL_TX_DIV3_REF_EN` is defined; see Configuration.

## Operation
- State machine with states IDLE, SHIFT and GAP, plus a shift register (DATA_WIDTH bits), a bit counter (clog2(DATA_WIDTH+1) bits) and a gap counter (clog2(GAP_CYCLES+1) bits, minimum 1).
- IDLE:
  - `din_ready` = 1.
  - On `din_valid && din_ready`: load `din` into the shift register, clear the bit counter, go to SHIFT.
- SHIFT:
  - `dout` = shift register MSB; `dout_valid` = 1.
  - `dout_sof` = 1 when the bit counter is 0.
  - `dout_eof` = 1 when the bit counter is DATA_WIDTH-1.
  - Each cycle, shift left by 1 and increment the counter.
  - On the eof cycle: go to GAP if GAP_CYCLES > 0, otherwise go to IDLE.
- GAP:
  - `dout_valid` = 0.
  - Count GAP_CYCLES cycles, then go to IDLE.
- `din_ready` = 0 in SHIFT and GAP. `din_valid` in those states is ignored, and `din` is not sampled.
- `busy` = 1 in SHIFT and GAP, 0 in IDLE.
- Whenever `dout_valid` = 0: `dout`, `dout_sof` and `dout_eof` are all 0.
- DATA_WIDTH = 1: `dout_sof` and `dout_eof` are both asserted in the single SHIFT cycle.
- All outputs decode directly from registered state; there is no combinational path from `din`/`din_valid` to any output except `din_ready`, which depends on state and `reset` only.

## Timing
- Word accepted at cycle T (IDLE, `din_valid` = 1):
  - MSB on `dout` at T+1, with `dout_sof` = 1.
  - LSB at T+DATA_WIDTH, with `dout_eof` = 1.
  - GAP occupies T+DATA_WIDTH+1 through T+DATA_WIDTH+GAP_CYCLES.
  - `din_ready` is 1 again at T+DATA_WIDTH+GAP_CYCLES+1.
- Sustained throughput: one word per DATA_WIDTH+GAP_CYCLES+1 cycles.
- Reset values: state IDLE, shift register 0, both counters 0. `dout`, `dout_valid`, `dout_sof`, `dout_eof`, `busy` and `exp_div3` are 0.
- `din_ready` = 0 while `reset` is high.
- Reset mid-word: the in-flight word is discarded with no `dout_eof` emitted. The cycle after reset deasserts, the block is in IDLE with `din_ready` = 1.

## Configuration
- `SERIAL_TX_DIV3_REF_EN` defined:
  - Adds the `exp_div3` port and a 2-bit residue register r.
  - In each SHIFT cycle, n = (2·r_used + `dout`) mod 3, where r_used = 0 when `dout_sof` = 1 and r_used = r otherwise.
  - `exp_div3` = (n == 0); r <= n.
  - `exp_div3` = 0 when `dout_valid` = 0.
  - A divisible-by-3 receiver, fed `dout` and reset on `dout_sof`, must output the same sequence one cycle later.
- `SERIAL_TX_DIV3_REF_EN` undefined: the `exp_div3` port and the residue logic are absent; all other behaviour is identical.

## Test plan
- DATA_WIDTH = 8, GAP_CYCLES = 1, `din` = 0xA5 accepted at T:
  - `dout` = 1,0,1,0,0,1,0,1 on T+1..T+8.
  - `dout_sof` only at T+1; `dout_eof` only at T+8.
  - `dout_valid` = 0 at T+9; `din_ready` = 1 at T+10.
- `SERIAL_TX_DIV3_REF_EN` defined, `din` = 0x06: `exp_div3` = 1,1,1,1,1,0,1,1 on T+1..T+8.
- GAP_CYCLES = 0, `din_valid` held high with words 0xFF then 0x00:
  - Second word accepted at T+9.
  - Its MSB appears at T+10 with `dout_sof` = 1.
  - `din` changes during SHIFT do not alter the output bits.
- `reset` pulsed at T+4 mid-word:
  - At T+5 all outputs are 0 and `din_ready` = 1.
  - Next word starts cleanly with `dout_sof` = 1.
- DATA_WIDTH = 1, `din` = 1: single cycle with `dout` = 1, `dout_sof` = `dout_eof` = 1, and `exp_div3` = 0 (when enabled).
